// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined IEEE-754 multiplier.
package fp_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [2:0] {
      ZERO,
      SUB,
      NORM,
      INF,
      NAN
   } fp_class_t;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Exponent bias for a given exponent width
   function automatic int unsigned fp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 32'd1)) - 32'd1;
   endfunction

   // Positive infinity bit pattern, right-aligned in MAX_W bits
   function automatic logic [MAX_W-1:0] inf_word(input int unsigned exp_w, input int unsigned man_w);
      logic [MAX_W-1:0] one;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      return ((one << exp_w) - one) << man_w;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
   function automatic logic [MAX_W-1:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
      logic [MAX_W-1:0] one;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      return inf_word(exp_w, man_w) | (one << (man_w - 32'd1));
   endfunction

   // Operand classification from exponent/fraction summary bits
   function automatic fp_class_t classify(input logic exp_ones, input logic exp_zero, input logic frac_zero);
      fp_class_t c;
      if (exp_zero)      c = frac_zero ? ZERO : SUB;
      else if (exp_ones) c = frac_zero ? INF : NAN;
      else               c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even, range check and pack a finite product.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   sign,
   input  logic [EXP_W+1:0]       exp_sum,
   input  logic [2*MAN_W+1:0]     prod,
   output logic [EXP_W+MAN_W:0]   word,
   output fp_flags_t              flags
);

   localparam int unsigned P  = MAN_W + 1;
   localparam int unsigned PW = 2 * P;
   localparam int unsigned EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((32'd1 << EXP_W) - 32'd1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   logic [PW-1:0]    norm;
   logic [EW-1:0]    exp_n;
   logic [EW-1:0]    exp_r;
   logic             guard;
   logic             rnd;
   logic             sticky;
   logic [P:0]       mant_r;
   logic [MAN_W-1:0] frac;

   // Leading-one alignment, RNE increment, carry re-normalisation and packing
   always_comb begin
      norm   = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
      exp_n  = prod[PW-1] ? exp_sum + EW'(1) : exp_sum;
      guard  = norm[P-1];
      rnd    = norm[P-2];
      sticky = |norm[P-3:0];
      mant_r = {1'b0, norm[PW-1:P]} + (P+1)'(guard & (rnd | sticky | norm[P]));
      exp_r  = exp_n + EW'(mant_r[P]);
      frac   = mant_r[P] ? mant_r[P-1:1] : mant_r[P-2:0];
      flags  = '0;
      word   = {sign, exp_r[EXP_W-1:0], frac};
      if ($signed(exp_r) >= EXP_MAX) begin
         word           = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags.overflow = 1'b1;
         flags.inexact  = 1'b1;
      end else if ($signed(exp_r) <= EXP_ZERO) begin
         word            = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags.underflow = 1'b1;
         flags.inexact   = 1'b1;
      end else begin
         flags.inexact = guard | rnd | sticky;
      end
   end

endmodule

// File: rtl/nmul.sv
// Unsigned W x W -> 2W combinational multiplier.
module nmul #(
   parameter int unsigned W = 24
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   localparam int unsigned PW = 2 * W;

   assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready flow control.
module fmul_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out,
   output logic [3:0]             flags
);

   import fp_pkg::*;

   localparam int unsigned N    = 1 + EXP_W + MAN_W;
   localparam int unsigned P    = MAN_W + 1;
   localparam int unsigned EW   = EXP_W + 2;
   localparam int unsigned BIAS = fp_bias(EXP_W);

   // Operand decode
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   fp_class_t        cls_a, cls_b;
   logic             snan_c;
   logic [EW-1:0]    exp_sum_c;

   // Stage 1 registers
   logic             s1_v;
   logic             s1_sign;
   fp_class_t        s1_cls_a, s1_cls_b;
   logic             s1_snan;
   logic [EW-1:0]    s1_exp;
   logic [P-1:0]     s1_ma, s1_mb;

   // Stage 2 registers
   logic             s2_v;
   logic             s2_sign;
   logic [EW-1:0]    s2_exp;
   logic [2*P-1:0]   s2_prod;
   logic             s2_spec;
   logic [N-1:0]     s2_spec_word;
   fp_flags_t        s2_spec_flags;

   logic [2*P-1:0]   prod_c;
   logic             spec_c;
   logic [N-1:0]     spec_word_c;
   fp_flags_t        spec_flags_c;
   logic             any_nan, any_inf, any_zero;
   logic [N-1:0]     rp_word;
   fp_flags_t        rp_flags;

   logic             out_free;
   logic             s2_open;

   assign ea = a[N-2:MAN_W];
   assign eb = b[N-2:MAN_W];
   assign fa = a[MAN_W-1:0];
   assign fb = b[MAN_W-1:0];

   // Classify operands; subnormals are flushed to zero before classification
   always_comb begin
      cls_a = classify(&ea, ~|ea, ~|fa);
      cls_b = classify(&eb, ~|eb, ~|fb);
      if (cls_a == SUB) cls_a = ZERO;
      if (cls_b == SUB) cls_b = ZERO;
      snan_c    = ((cls_a == NAN) && !fa[MAN_W-1]) || ((cls_b == NAN) && !fb[MAN_W-1]);
      exp_sum_c = EW'(ea) + EW'(eb) - EW'(BIAS);
   end

   // Ready chain: a stage may load when it is empty or its contents move on
   assign out_free = !out_valid | out_ready;
   assign s2_open  = !s2_v | out_free;
   assign in_ready = !s1_v | s2_open;

   // Stage 1: unpack and classify
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
      end else if (in_ready) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_sign  <= a[N-1] ^ b[N-1];
            s1_cls_a <= cls_a;
            s1_cls_b <= cls_b;
            s1_snan  <= snan_c;
            s1_exp   <= exp_sum_c;
            s1_ma    <= {1'b1, fa};
            s1_mb    <= {1'b1, fb};
         end
      end
   end

   nmul #(.W(P)) u_nmul (
      .a (s1_ma),
      .b (s1_mb),
      .p (prod_c)
   );

   // Special-value resolution in priority order: NaN / INF*ZERO, INF, ZERO
   always_comb begin
      spec_c       = 1'b0;
      spec_word_c  = '0;
      spec_flags_c = '0;
      any_nan  = (s1_cls_a == NAN)  || (s1_cls_b == NAN);
      any_inf  = (s1_cls_a == INF)  || (s1_cls_b == INF);
      any_zero = (s1_cls_a == ZERO) || (s1_cls_b == ZERO);
      if (any_nan || (any_inf && any_zero)) begin
         spec_c               = 1'b1;
         spec_word_c          = N'(qnan_word(EXP_W, MAN_W));
         spec_flags_c.invalid = s1_snan | (any_inf & any_zero);
      end else if (any_inf) begin
         spec_c         = 1'b1;
         spec_word_c    = N'(inf_word(EXP_W, MAN_W));
         spec_word_c[N-1] = s1_sign;
      end else if (any_zero) begin
         spec_c           = 1'b1;
         spec_word_c[N-1] = s1_sign;
      end
   end

   // Stage 2: mantissa product and special result
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v <= 1'b0;
      end else if (s2_open) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_prod       <= prod_c;
            s2_spec       <= spec_c;
            s2_spec_word  <= spec_word_c;
            s2_spec_flags <= spec_flags_c;
         end
      end
   end

   fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
      .sign    (s2_sign),
      .exp_sum (s2_exp),
      .prod    (s2_prod),
      .word    (rp_word),
      .flags   (rp_flags)
   );

   // Stage 3: rounded result register, held while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         flags     <= '0;
      end else if (out_free) begin
         out_valid <= s2_v;
         if (s2_v) begin
            out   <= s2_spec ? s2_spec_word  : rp_word;
            flags <= s2_spec ? s2_spec_flags : rp_flags;
         end
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (binary32).
module tb_fmul_pipe;

   localparam int NV = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic [3:0]  flags;

   int tests_run = 0;
   int fails = 0;
   logic [35:0] sb [$];

   // Operand A, operand B, expected product, expected {invalid,overflow,underflow,inexact}
   logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
                            32'h00800000, 32'h00000001, 32'h40000000, 32'hFF800000, 32'h7F800001,
                            32'h7FC00000, 32'h3F800001, 32'h3F800003, 32'h3F800001, 32'h3F800000};
   logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800001, 32'hBF800000, 32'h00000000, 32'h40000000,
                            32'h00800000, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000,
                            32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFE, 32'h3F800000};
   logic [31:0] vo [NV] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h7FC00000, 32'h7F800000,
                            32'h00000000, 32'h00000000, 32'h40C00000, 32'hFF800000, 32'h7FC00000,
                            32'h7FC00000, 32'h3FC00002, 32'h3FC00004, 32'h40000000, 32'h3F800000};
   logic [3:0]  vf [NV] = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0101,
                            4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                            4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};

   fmul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++;
      if (out !== 32'h0) begin fails++; $display("FAIL reset_out: got %h want 00000000", out); end
      tests_run++;
      if (flags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %b want 0000", flags); end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      logic [35:0] exp_rec;
      a = va[0]; b = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_accept: got in_ready %b want 1", in_ready); end
      sb.push_back({vo[0], vf[0]});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle1: got out_valid %b want 0", out_valid); end
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle2: got out_valid %b want 0", out_valid); end
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL lat_cycle3: got out_valid %b want 1", out_valid); end
      exp_rec = (sb.size() > 0) ? sb.pop_front() : 36'h0;
      tests_run++;
      if (out !== exp_rec[35:4] || flags !== exp_rec[3:0])
         begin fails++; $display("FAIL lat_result: got %h/%b want %h/%b", out, flags, exp_rec[35:4], exp_rec[3:0]); end
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      logic [35:0] exp_rec;
      logic got;
      for (int i = 1; i < NV; i++) begin
         a = va[i]; b = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         if (!got) begin
            tests_run++; fails++; $display("FAIL vec%0d_accept: got no in_ready want accept", i);
         end else begin
            sb.push_back({vo[i], vf[i]});
         end
         @(posedge clk); #1 in_valid = 1'b0;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         tests_run++;
         if (!got) begin
            fails++; $display("FAIL vec%0d_timeout: got no out_valid want result", i);
         end else begin
            exp_rec = (sb.size() > 0) ? sb.pop_front() : 36'h0;
            if (out !== exp_rec[35:4] || flags !== exp_rec[3:0])
               begin fails++; $display("FAIL vec%0d: got %h/%b want %h/%b", i, out, flags, exp_rec[35:4], exp_rec[3:0]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [35:0] exp_rec;
      logic [31:0] held;
      logic        held_v = 1'b0;
      logic        saw_block = 1'b0;
      logic        acc;
      int          issued = 0;
      int          recv = 0;
      a = va[0]; b = vb[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         out_ready = !(cyc >= 4 && cyc < 7);
         @(negedge clk);
         if (out_valid && !out_ready) begin
            if (held_v) begin
               tests_run++;
               if (out !== held) begin fails++; $display("FAIL b2b_stall_stable: got %h want %h", out, held); end
            end
            held = out; held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (out_valid && out_ready) begin
            exp_rec = (sb.size() > 0) ? sb.pop_front() : 36'h0;
            tests_run++;
            if (out !== exp_rec[35:4] || flags !== exp_rec[3:0])
               begin fails++; $display("FAIL b2b_result%0d: got %h/%b want %h/%b", recv, out, flags, exp_rec[35:4], exp_rec[3:0]); end
            recv++;
         end
         acc = in_valid && in_ready;
         if (acc) sb.push_back({vo[issued], vf[issued]});
         @(posedge clk); #1;
         if (acc) begin
            issued++;
            if (issued < 8) begin a = va[issued]; b = vb[issued]; end
            else in_valid = 1'b0;
         end
      end
      tests_run++;
      if (recv != 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", recv); end
      tests_run++;
      if (saw_block !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_drop: got %b want 1", saw_block); end
      out_ready = 1'b1;
      repeat (3) begin @(negedge clk); if (out_valid) recv++; @(posedge clk); #1; end
      tests_run++;
      if (recv != 8 || sb.size() != 0)
         begin fails++; $display("FAIL b2b_no_dup: got %0d results/%0d pending want 8/0", recv, sb.size()); end
   endtask

   task automatic test_reset_flush();
      logic [35:0] exp_rec;
      logic        stale = 1'b0;
      logic        got = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = va[k]; b = vb[k];
         @(negedge clk);
         tests_run++;
         if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_accept%0d: got %b want 1", k, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_inflight: got %b want 1", out_valid); end
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop: got %b want 0", out_valid); end
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) stale = 1'b1; @(posedge clk); #1; end
      tests_run++;
      if (stale !== 1'b0) begin fails++; $display("FAIL flush_stale: got %b want 0", stale); end
      a = va[7]; b = vb[7]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) sb.push_back({vo[7], vf[7]});
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      tests_run++;
      if (!got) begin
         fails++; $display("FAIL flush_recover_timeout: got no out_valid want result");
      end else begin
         exp_rec = (sb.size() > 0) ? sb.pop_front() : 36'h0;
         if (out !== exp_rec[35:4] || flags !== exp_rec[3:0])
            begin fails++; $display("FAIL flush_recover: got %h/%b want %h/%b", out, flags, exp_rec[35:4], exp_rec[3:0]); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_back_to_back();
      test_reset_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
